text_screen_buffer: RTL and testbench
=====================================

# text_screen_buffer

Parametrised text-mode character buffer between the character writer (console/UART/keypad logic) and the VGA character generator. It holds a COLS×ROWS grid of character codes and owns a hardware cursor: a valid/ready stream of characters is placed, wrapped and line-fed automatically. A registered read port serves the pixel pipeline. A sweeping clear engine and optional hardware scroll replace the fixed, preloaded, combinational-read screen RAM.

## Interface
- COLS, default 80: characters per row.
- ROWS, default 30: rows on screen.
- CHAR_W, default 8: bits per character code.
- BLANK, default 8'h20: fill code used by clear and scroll.
- INIT_CLEAR, default 1: when 1, a full clear runs automatically after reset.
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous assert, active-low.
- wr_valid  in  1  character write request.
- wr_char  in  CHAR_W  character or control code.
- wr_ready  out  1  high when a character can be accepted (IDLE state only).
- clr_req  in  1  single-cycle clear-screen request.
- busy  out  1  high during CLEAR or SCROLL_CLR.
- cur_col  out  clog2(COLS)  cursor column.
- cur_row  out  clog2(ROWS)  cursor logical row.
- rd_col  in  clog2(COLS)  pixel-side column.
- rd_row  in  clog2(ROWS)  pixel-side logical row.
- rd_char  out  CHAR_W  character at (rd_row, rd_col), registered.

## Operation
- States: IDLE, CLEAR, SCROLL_CLR.
- Reset values: cur_col=0, cur_row=0, top=0, rd_char=BLANK. State is CLEAR if INIT_CLEAR=1, else IDLE; busy and wr_ready follow the state. Memory contents are not reset.
- Address mapping: phys_row = (logical_row + top) mod ROWS; addr = phys_row*COLS + col. The same mapping applies to writes and reads.
- A transfer occurs when wr_valid and wr_ready are both high. Codes:
  - Printable (>= 0x20): written at the cursor, then col+1. At col = COLS-1: col=0 and a row advance.
  - 0x0A LF: col=0, row advance, no write.
  - 0x0D CR: col=0.
  - 0x08 BS: col-1 if col>0, else no-op, no write.
  - Other codes < 0x20: accepted and ignored.
- Row advance: if row < ROWS-1 then row+1. Otherwise the behaviour depends on the configuration below.
- clr_req in IDLE: enters CLEAR, which writes BLANK to all ROWS*COLS locations in ascending address order. Cursor=(0,0) and top=0 on entry.
  - clr_req beats wr_valid in the same cycle; that character is not accepted.
  - clr_req during CLEAR is ignored.
  - clr_req during SCROLL_CLR aborts the scroll and starts CLEAR.
- Read port: rd_col >= COLS or rd_row >= ROWS returns BLANK.
- Simultaneous read and write to the same address: the read returns old data.

## Timing
- Write and cursor/top update occur on the acceptance edge. Throughput is 1 char/cycle in IDLE.
- Read latency is 1 cycle: the address presented at edge N gives rd_char valid after edge N+1. A write accepted at edge N is readable by an address presented at edge N+1.
- CLEAR lasts exactly ROWS*COLS cycles. busy drops and wr_ready rises in the cycle after the last write.
- SCROLL_CLR lasts exactly COLS cycles. wr_ready is low throughout.
- rst_n asserted mid-CLEAR or mid-SCROLL_CLR: immediate return to reset values. With INIT_CLEAR=1, the clear restarts from address 0.

## Configuration
- TEXTBUF_SCROLL_EN defined: a row advance from ROWS-1 keeps row=ROWS-1 and sets top=(top+1) mod ROWS. The block then enters SCROLL_CLR, blanking the new bottom physical row; no memory is copied.
- TEXTBUF_SCROLL_EN undefined: a row advance from ROWS-1 wraps row to 0 with no clear. top stays 0 permanently, and SCROLL_CLR logic is absent.

## Structure
- Package textbuf_pkg holds:
  - the state enum (IDLE, CLEAR, SCROLL_CLR);
  - ASCII constants ASCII_LF, ASCII_CR, ASCII_BS, ASCII_SPACE;
  - width helper functions.
- Sub-module text_ram_1r1w: simple dual-port, depth COLS*ROWS, one write port and a registered read port, inferring block RAM. The top level holds the FSM, cursor, top pointer and address mapping.

## Test plan
- Reset with INIT_CLEAR=1, 80x30: busy=1 for exactly 2400 cycles, then wr_ready=1. Every location reads 8'h20 and cursor=(0,0).
- Stream "AB" then 0x0A then "C": (0,0)='A', (0,1)='B', (1,0)='C', cursor=(1,1). A read of (1,0) presented one cycle after acceptance returns 'C'.
- 80 printable chars from (0,0): wrap gives cursor=(1,0). BS at col 0 is a no-op; BS at col 5 gives col 4 with memory unchanged.
- TEXTBUF_SCROLL_EN: fill rows with row-index chars, then LF at row 29. Logical row 0 shows the old row 1, row 29 reads BLANK, wr_ready is low exactly 80 cycles, and cursor=(29,0).
- Without the macro, LF at row 29 gives cursor=(0,0) and row 0 content is retained. rd_col=80 returns BLANK.
- clr_req and wr_valid in the same cycle: the character is not written and CLEAR starts. clr_req during SCROLL_CLR gives a full 2400-cycle CLEAR. rst_n pulse mid-CLEAR gives cursor=(0,0) and the clear restarts.

Source files
------------

// File: rtl/textbuf_pkg.sv
// Shared types and constants for the text-mode screen buffer.
// Hardware scroll is enabled by defining TEXTBUF_SCROLL_EN.
package textbuf_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR      = 2'd1,
    SCROLL_CLR = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Index width for a count of n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/text_ram_1r1w.sv
// Simple dual-port character RAM: one write port and one registered read
// port. A read of the address being written returns the old contents.
module text_ram_1r1w #(
  parameter int DEPTH = 2400,
  parameter int AW    = 12,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/text_screen_buffer.sv
// Text-mode character buffer with hardware cursor, clear engine and
// registered read port. Define TEXTBUF_SCROLL_EN for hardware scroll.
module text_screen_buffer
  import textbuf_pkg::*;
#(
  parameter int                COLS       = 80,
  parameter int                ROWS       = 30,
  parameter int                CHAR_W     = 8,
  parameter logic [CHAR_W-1:0] BLANK      = CHAR_W'(8'h20),
  parameter int                INIT_CLEAR = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  input  logic [CHAR_W-1:0]        wr_char,
  output logic                     wr_ready,
  input  logic                     clr_req,
  output logic                     busy,
  output logic [idx_w(COLS)-1:0]   cur_col,
  output logic [idx_w(ROWS)-1:0]   cur_row,
  input  logic [idx_w(COLS)-1:0]   rd_col,
  input  logic [idx_w(ROWS)-1:0]   rd_row,
  output logic [CHAR_W-1:0]        rd_char
);

  localparam int CW    = idx_w(COLS);
  localparam int RW    = idx_w(ROWS);
  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = idx_w(DEPTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [RW-1:0]   top_q, top_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            blank_q;
  logic            adv_s;
  logic            rd_oor_s;
  logic            we_s;
  logic [AW-1:0]   waddr_s;
  logic [CHAR_W-1:0] wdata_s;
  logic [AW-1:0]   raddr_s;
  logic [CHAR_W-1:0] ram_rdata_s;

  // Logical row is rotated by the top pointer before forming the linear address.
  function automatic logic [AW-1:0] map_addr(input logic [RW-1:0] row,
                                             input logic [RW-1:0] top,
                                             input logic [CW-1:0] col);
    logic [RW:0] phys;
    phys = {1'b0, row} + {1'b0, top};
    if (int'(phys) >= ROWS) begin
      phys = phys - (RW+1)'(ROWS);
    end else begin
      phys = phys;
    end
    return AW'(phys) * AW'(COLS) + AW'(col);
  endfunction

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    adv_s   = 1'b0;
    we_s    = 1'b0;
    waddr_s = map_addr(row_q, top_q, col_q);
    wdata_s = wr_char;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
          top_d   = '0;
        end else if (wr_valid) begin
          if (wr_char >= CHAR_W'(ASCII_SPACE)) begin
            we_s = 1'b1;
            if (int'(col_q) == COLS - 1) begin
              col_d = '0;
              adv_s = 1'b1;
            end else begin
              col_d = col_q + CW'(1);
            end
          end else if (wr_char == CHAR_W'(ASCII_LF)) begin
            col_d = '0;
            adv_s = 1'b1;
          end else if (wr_char == CHAR_W'(ASCII_CR)) begin
            col_d = '0;
          end else if (wr_char == CHAR_W'(ASCII_BS)) begin
            col_d = (col_q != '0) ? col_q - CW'(1) : col_q;
          end else begin
            col_d = col_q;
          end
        end else begin
          state_d = IDLE;
        end
        // Bottom-row advance either scrolls the window or wraps to the top.
        if (adv_s) begin
          if (int'(row_q) != ROWS - 1) begin
            row_d = row_q + RW'(1);
          end else begin
`ifdef TEXTBUF_SCROLL_EN
            top_d   = (int'(top_q) == ROWS - 1) ? '0 : top_q + RW'(1);
            state_d = SCROLL_CLR;
            cnt_d   = '0;
`else
            row_d   = '0;
`endif
          end
        end else begin
          row_d = row_d;
        end
      end
      CLEAR: begin
        we_s    = 1'b1;
        waddr_s = cnt_q;
        wdata_s = BLANK;
        if (int'(cnt_q) == DEPTH - 1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + AW'(1);
        end
      end
`ifdef TEXTBUF_SCROLL_EN
      SCROLL_CLR: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
          top_d   = '0;
        end else begin
          // The old top physical row has become the new bottom line.
          we_s    = 1'b1;
          waddr_s = map_addr(RW'(ROWS - 1), top_q, CW'(cnt_q));
          wdata_s = BLANK;
          if (int'(cnt_q) == COLS - 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + AW'(1);
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_oor_s = (int'(rd_col) >= COLS) || (int'(rd_row) >= ROWS);
    if (rd_oor_s) begin
      raddr_s = '0;
    end else begin
      raddr_s = map_addr(rd_row, top_q, rd_col);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
      col_q   <= '0;
      row_q   <= '0;
      top_q   <= '0;
      cnt_q   <= '0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      blank_q <= rd_oor_s;
    end
  end

  text_ram_1r1w #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (CHAR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (wdata_s),
    .raddr_i (raddr_s),
    .rdata_o (ram_rdata_s)
  );

  assign rd_char  = blank_q ? BLANK : ram_rdata_s;
  assign wr_ready = (state_q == IDLE);
  assign busy     = (state_q == CLEAR) || (state_q == SCROLL_CLR);
  assign cur_col  = col_q;
  assign cur_row  = row_q;

endmodule

// File: tb/tb_text_screen_buffer.sv
// Randomized self-checking bench for text_screen_buffer against a logical
// screen model (2-D array of rows, scrolling by shifting rows).
module tb_text_screen_buffer;

  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam logic [7:0] BL = 8'h20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_char = 8'h00;
  logic       clr_req = 1'b0;
  logic [6:0] rd_col = 7'd0;
  logic [4:0] rd_row = 5'd0;
  logic       wr_ready;
  logic       busy;
  logic [6:0] cur_col;
  logic [4:0] cur_row;
  logic [7:0] rd_char;

  int checks = 0;
  int failures = 0;

  logic [7:0] scr [ROWS][COLS];
  int m_col = 0;
  int m_row = 0;

  always #5 clk = ~clk;

  text_screen_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_char  (wr_char),
    .wr_ready (wr_ready),
    .clr_req  (clr_req),
    .busy     (busy),
    .cur_col  (cur_col),
    .cur_row  (cur_row),
    .rd_col   (rd_col),
    .rd_row   (rd_row),
    .rd_char  (rd_char)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        scr[r][c] = BL;
    m_col = 0;
    m_row = 0;
  endtask

  task automatic model_adv();
    if (m_row < ROWS - 1) begin
      m_row++;
    end else begin
`ifdef TEXTBUF_SCROLL_EN
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++)
          scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++)
        scr[ROWS-1][c] = BL;
`else
      m_row = 0;
`endif
    end
  endtask

  task automatic model_put(input logic [7:0] ch);
    if (ch >= 8'h20) begin
      scr[m_row][m_col] = ch;
      if (m_col == COLS - 1) begin
        m_col = 0;
        model_adv();
      end else begin
        m_col++;
      end
    end else if (ch == 8'h0A) begin
      m_col = 0;
      model_adv();
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h08) begin
      if (m_col > 0) m_col--;
    end
  endtask

  task automatic send(input logic [7:0] ch);
    int n;
    n = 0;
    wr_char  = ch;
    wr_valid = 1'b1;
    while (!wr_ready && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check("send_timeout", n, 0);
    tick();
    wr_valid = 1'b0;
    model_put(ch);
  endtask

  task automatic rd(input int r, input int c, output logic [7:0] v);
    rd_row = 5'(r);
    rd_col = 7'(c);
    tick();
    v = rd_char;
  endtask

  task automatic scan(input string tag);
    int bad;
    logic [7:0] v;
    bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        rd(r, c, v);
        if (v !== scr[r][c]) bad++;
      end
    check(tag, bad, 0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 10000) begin
      tick();
      n++;
    end
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, cur_col, m_col);
    check({tag, "_row"}, cur_row, m_row);
  endtask

  task automatic do_clear(input string tag);
    int n;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wait_idle(n);
    check(tag, n, COLS * ROWS);
    model_clear();
  endtask

  initial begin
    int n;
    int sel;
    logic [7:0] v;
    logic [7:0] ch;

    // Reset and automatic initial clear.
    #23;
    check("rst_rd_char", rd_char, BL);
    check("rst_busy", busy, 1);
    check("rst_ready", wr_ready, 0);
    check("rst_col", cur_col, 0);
    check("rst_row", cur_row, 0);
    rst_n = 1'b1;
    wait_idle(n);
    check("init_clear_len", n, COLS * ROWS);
    check("init_ready", wr_ready, 1);
    model_clear();
    check_cursor("init_cur");
    scan("init_scan");

    // "AB" LF "C", then immediate read of the new character.
    send(8'h41); send(8'h42); send(8'h0A); send(8'h43);
    rd(1, 0, v);
    check("rd_after_write", v, 8'h43);
    check_cursor("abc_cur");
    rd(0, 0, v); check("abc_00", v, 8'h41);
    rd(0, 1, v); check("abc_01", v, 8'h42);

    // Row wrap after a full line, and backspace boundaries.
    do_clear("clr_len");
    for (int i = 0; i < COLS; i++) send(8'(8'h30 + (i % 10)));
    check_cursor("wrap_cur");
    send(8'h08);
    check_cursor("bs_col0");
    for (int i = 0; i < 5; i++) send(8'h78);
    send(8'h08);
    check_cursor("bs_col5");
    rd(1, 4, v); check("bs_mem", v, 8'h78);

    // Out-of-range reads return BLANK.
    rd(0, COLS, v);     check("oor_col", v, BL);
    rd(ROWS, 0, v);     check("oor_row", v, BL);
    rd(31, 127, v);     check("oor_both", v, BL);

    // clr_req beats wr_valid: (0,0) must still hold its old character
    // when read just before the clear overwrites it.
    rd_row = 5'd0; rd_col = 7'd0;
    clr_req = 1'b1; wr_valid = 1'b1; wr_char = 8'h51;
    tick();
    clr_req = 1'b0; wr_valid = 1'b0;
    check("clrwr_busy", busy, 1);
    tick();
    check("clrwr_nowrite", rd_char, scr[0][0]);
    wait_idle(n);
    check("clrwr_len", n, COLS * ROWS - 1);
    model_clear();
    check_cursor("clrwr_cur");

    // Random character stream with idle gaps.
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 70)      ch = 8'($urandom_range(8'h21, 8'h7E));
      else if (sel < 80) ch = 8'h0A;
      else if (sel < 85) ch = 8'h0D;
      else if (sel < 90) ch = 8'h08;
      else if (sel < 95) ch = 8'($urandom_range(1, 7));
      else               ch = 8'h20;
      send(ch);
      if ($urandom_range(0, 3) == 0) tick();
      if (i % 250 == 0) check_cursor("rand_cur");
    end
    check_cursor("rand_end_cur");
    scan("rand_scan");

    // Fill every row with its own code, then LF from the bottom row.
    do_clear("fill_clr_len");
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS - 1; c++) send(8'(8'h40 + r));
      if (r < ROWS - 1) send(8'h0A);
    end
    check_cursor("fill_cur");
    wr_char = 8'h0A; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    model_put(8'h0A);
    n = 0;
    while (!wr_ready && n < 1000) begin
      tick();
      n++;
    end
`ifdef TEXTBUF_SCROLL_EN
    check("scroll_stall", n, COLS);
    check("scroll_row", cur_row, ROWS - 1);
`else
    check("wrap_stall", n, 0);
    check("wrap_row", cur_row, 0);
`endif
    check("bottom_lf_col", cur_col, 0);
    check_cursor("bottom_lf_cur");
    scan("bottom_lf_scan");

`ifdef TEXTBUF_SCROLL_EN
    // clr_req during a scroll aborts it and runs a full clear.
    wr_char = 8'h0A; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    wait_idle(n);
    check("scroll_abort_len", n, COLS * ROWS);
    model_clear();
    check_cursor("scroll_abort_cur");
    scan("scroll_abort_scan");
`endif

    // Reset pulse mid-clear restarts the clear from the beginning.
    send(8'h41); send(8'h42);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    rst_n = 1'b0;
    #2;
    check("midrst_col", cur_col, 0);
    check("midrst_row", cur_row, 0);
    check("midrst_busy", busy, 1);
    check("midrst_rd", rd_char, BL);
    rst_n = 1'b1;
    wait_idle(n);
    check("midrst_len", n, COLS * ROWS);
    model_clear();
    rd(ROWS - 1, COLS - 1, v);
    check("midrst_last", v, BL);
    rd(0, 0, v);
    check("midrst_first", v, BL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
